pc_fetch_ctrl: RTL

Owns the program counter and sequences instruction fetch for the MIPS core. It issues one request at a time to instruction memory with a ready handshake and holds the fetched instruction until decode accepts it. It applies branch/jump redirects from execute and halts on a misaligned target. It replaces the free-running PC register as the source of fetch addresses.

---
 rtl/pc_fetch_ctrl.sv | 104 ++++++++++
 1 files changed

// File: rtl/pc_fetch_ctrl.sv
// pc_fetch_ctrl: owns the program counter and sequences instruction fetch.
// Issues one instruction-memory request at a time and holds each fetched word
// until decode accepts it. Branch/jump redirects from execute override fetch.
// A misaligned redirect target halts fetch until reset.
// Every output is decoded from registered state only, so no input reaches an
// output combinationally.
module pc_fetch_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0040_0030
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic [31:0] pc,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
    output logic        fault,
    output logic [31:0] fault_addr
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        VALID = 2'd2,
        FAULT = 2'd3
    } state_t;

    state_t      state_r;
    logic [31:0] pc_r;
    logic [31:0] instr_r;
    logic [31:0] instr_pc_r;
    logic [31:0] fault_addr_r;

    // A fetch address is usable only when it sits on a 32-bit word boundary.
    function automatic logic is_word_aligned(input logic [31:0] addr);
        return (addr[1:0] == 2'b00);
    endfunction

    // Fetch sequencer: reset first, then redirect, then the memory/decode handshake.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r      <= IDLE;
            pc_r         <= RESET_PC;
            instr_r      <= 32'h0000_0000;
            instr_pc_r   <= 32'h0000_0000;
            fault_addr_r <= 32'h0000_0000;
        end else if ((state_r != FAULT) && redirect_valid) begin
            // The redirect wins over imem_ready and stall.
            // Any returning data is dropped, and a held instruction is squashed.
            if (is_word_aligned(redirect_target)) begin
                pc_r    <= redirect_target;
                state_r <= FETCH;
            end else begin
                fault_addr_r <= redirect_target;
                state_r      <= FAULT;
            end
        end else begin
            case (state_r)
                IDLE: begin
                    state_r <= FETCH;
                end
                FETCH: begin
                    if (imem_ready) begin
                        instr_r    <= imem_rdata;
                        instr_pc_r <= pc_r;
                        pc_r       <= pc_r + 32'd4;
                        state_r    <= VALID;
                    end else begin
                        state_r <= FETCH;
                    end
                end
                VALID: begin
                    if (!stall) begin
                        state_r <= FETCH;
                    end else begin
                        state_r <= VALID;
                    end
                end
                FAULT: begin
                    state_r <= FAULT;
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

    assign imem_req    = (state_r == FETCH);
    assign imem_addr   = pc_r;
    assign pc          = pc_r;
    assign instr_valid = (state_r == VALID);
    assign instr       = instr_r;
    assign instr_pc    = instr_pc_r;
    assign fault       = (state_r == FAULT);
    assign fault_addr  = fault_addr_r;

endmodule
